// File: rtl/surf_wb_arb_pkg.sv
// Shared types and defaults for the SURF two-master WISHBONE arbiter.
package surf_wb_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant0,
    StGrant1,
    StAbort0,
    StAbort1
  } arb_state_e;

  localparam int unsigned DefTimeoutCycles = 1024;
  localparam logic [31:0] DefTimeoutData   = 32'hDEADDEAD;

endpackage

// File: rtl/surf_wb_timeout.sv
// Watchdog for a strobed access: counts unanswered strobe cycles and flags
// expiry on the last allowed cycle so the arbiter can abort the access.
module surf_wb_timeout
  import surf_wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [15:0] LastCount = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_q, count_d;

  // Clear dominates; otherwise count every enabled cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 16'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A response in the same cycle clears, so it beats expiry.
  assign expire_o = enable_i & ~clear_i & (count_q == LastCount);

endmodule

// File: rtl/surf_wb_arbiter.sv
// Round-robin two-master WISHBONE arbiter with bus hold and access watchdog.
module surf_wb_arbiter
  import surf_wb_arb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 22,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DefTimeoutData
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  output logic [1:0]              grant_o,
  output logic [15:0]             timeout_count_o
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0 = m0 won last, 1 = m1 won last
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        in_grant, wdog_enable, wdog_clear, wdog_expire;

  assign in_grant    = (state_q == StGrant0) || (state_q == StGrant1);
  assign wdog_enable = in_grant & s_stb_o;
  assign wdog_clear  = ~wdog_enable | s_ack_i | s_err_i;

  surf_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .clear_i (wdog_clear),
    .enable_i(wdog_enable),
    .expire_o(wdog_expire)
  );

  // Next-state: round-robin pick from idle, hold while CYC stays high.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
          state_d      = StGrant0;
          last_grant_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = StGrant1;
          last_grant_d = 1'b1;
        end
      end
      StGrant0: begin
        if (!m0_cyc_i) state_d = StIdle;
        else if (wdog_expire) state_d = StAbort0;
      end
      StGrant1: begin
        if (!m1_cyc_i) state_d = StIdle;
        else if (wdog_expire) state_d = StAbort1;
      end
      StAbort0, StAbort1: begin
        state_d = StIdle;
        if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, round-robin pointer and abort counter registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // Bus mux and response routing; everything idles to zero by default.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    unique case (state_q)
      StGrant0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i & m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        m0_dat_o = s_dat_i;
        grant_o  = 2'b01;
      end
      StGrant1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i & m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        m1_dat_o = s_dat_i;
        grant_o  = 2'b10;
      end
      StAbort0: begin
        m0_err_o = 1'b1;
        m0_dat_o = TIMEOUT_DATA;
        grant_o  = 2'b01;
      end
      StAbort1: begin
        m1_err_o = 1'b1;
        m1_dat_o = TIMEOUT_DATA;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
    // An access being killed by reset must not see a completion.
    if (wb_rst_i) begin
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
    end
  end

  assign timeout_count_o = tmo_cnt_q;

endmodule

// File: tb/tb_surf_wb_arbiter.sv
// Directed + randomized bench for surf_wb_arbiter with a transaction-level model.
module tb_surf_wb_arbiter;

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned T  = 16;
  localparam logic [DW-1:0] TDATA = 32'hDEADDEAD;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
  logic [1:0]    grant_o;
  logic [15:0]   timeout_count_o;

  always #5 clk = ~clk;

  surf_wb_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T),
    .TIMEOUT_DATA  (TDATA)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .grant_o(grant_o), .timeout_count_o(timeout_count_o)
  );

  int total_cnt = 0;
  int fail_cnt  = 0;

  // Reference model state: who won the last contest, how many aborts so far.
  int last_grant;
  int tmo_model;

  logic          e_we  [2];
  logic [AW-1:0] e_adr [2];
  logic [DW-1:0] e_dat [2];
  logic [SW-1:0] e_sel [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_ack_o : m1_ack_o;
  endfunction

  function automatic logic err_of(input int m);
    return (m == 0) ? m0_err_o : m1_err_o;
  endfunction

  function automatic logic [DW-1:0] dat_of(input int m);
    return (m == 0) ? m0_dat_o : m1_dat_o;
  endfunction

  task automatic drive(input int m, input bit on);
    if (m == 0) begin
      m0_cyc_i = on; m0_stb_i = on; m0_we_i = e_we[0];
      m0_adr_i = e_adr[0]; m0_dat_i = e_dat[0]; m0_sel_i = e_sel[0];
    end else begin
      m1_cyc_i = on; m1_stb_i = on; m1_we_i = e_we[1];
      m1_adr_i = e_adr[1]; m1_dat_i = e_dat[1]; m1_sel_i = e_sel[1];
    end
  endtask

  task automatic set_req(input int m, input bit on);
    if (on) begin
      e_we[m]  = 1'($urandom);
      e_adr[m] = AW'($urandom);
      e_dat[m] = $urandom;
      e_sel[m] = SW'($urandom);
    end
    drive(m, on);
  endtask

  // Called in the first strobe cycle of master m's access (settles first).
  task automatic serve(input int m, input int delay, input bit use_err, input bit release_bus);
    logic [DW-1:0] rd;
    #1;
    check("grant", grant_o, 64'(1 << m));
    check("s_cyc", s_cyc_o, 1);
    check("s_stb", s_stb_o, 1);
    check("s_we", s_we_o, e_we[m]);
    check("s_adr", s_adr_o, e_adr[m]);
    check("s_dat", s_dat_o, e_dat[m]);
    check("s_sel", s_sel_o, e_sel[m]);
    for (int i = 0; i < delay; i++) begin
      check("early_resp", {ack_of(m), err_of(m)}, 0);
      tick();
      #1;
    end
    rd = $urandom;
    s_dat_i = rd;
    if (use_err) s_err_i = 1'b1;
    else s_ack_i = 1'b1;
    #1;
    check("ack", ack_of(m), !use_err);
    check("err", err_of(m), use_err);
    check("rdata", dat_of(m), rd);
    check("other_resp", {ack_of(1 - m), err_of(1 - m)}, 0);
    tick();
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    if (release_bus) begin
      drive(m, 0);
      #1;
      check("drop_s_cyc", s_cyc_o, 0);
      check("drop_grant", grant_o, 64'(1 << m));
      check("drop_resp", {ack_of(m), err_of(m)}, 0);
    end
  endtask

  // From IDLE: raise the requested masters and serve them in model order.
  task automatic contest(input bit r0, input bit r1);
    int w;
    if (r0) set_req(0, 1);
    if (r1) set_req(1, 1);
    #1;
    check("idle_grant", grant_o, 0);
    check("idle_s_cyc", s_cyc_o, 0);
    w = (r0 && r1) ? 1 - last_grant : (r0 ? 0 : 1);
    tick();
    serve(w, int'($urandom_range(T - 2, 0)), ($urandom % 4) == 0, 1);
    last_grant = w;
    tick();
    check("gap_grant", grant_o, 0);
    if (r0 && r1) begin
      tick();
      serve(1 - w, int'($urandom_range(T - 2, 0)), 0, 1);
      last_grant = 1 - w;
      tick();
      check("gap_grant2", grant_o, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    for (int m = 0; m < 2; m++) begin
      e_we[m] = 1'b0; e_adr[m] = '0; e_dat[m] = '0; e_sel[m] = '0;
      drive(m, 0);
    end
    last_grant = 1;
    tmo_model  = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_tmo", timeout_count_o, 0);
    check("rst_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);

    // m0 single write, slave acks after 3 wait cycles.
    e_we[0] = 1'b1; e_adr[0] = 22'h000100; e_dat[0] = 32'h12345678; e_sel[0] = 4'hF;
    drive(0, 1);
    #1;
    check("t1_latency", s_cyc_o, 0);
    tick();
    serve(0, 3, 0, 1);
    last_grant = 0;
    tick();
    check("t1_idle", grant_o, 0);

    // Simultaneous request out of reset: m0 first, one idle cycle, then m1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_grant = 1;
    contest(1, 1);

    // m1 holds CYC for 4 back-to-back reads while m0 waits.
    set_req(1, 1);
    e_we[1] = 1'b0;
    drive(1, 1);
    tick();
    set_req(0, 1);
    serve(1, 2, 0, 0);
    for (int i = 1; i < 4; i++) begin
      set_req(1, 1);
      e_we[1] = 1'b0;
      drive(1, 1);
      serve(1, int'($urandom_range(3, 0)), 0, i == 3);
    end
    last_grant = 1;
    tick();
    check("t3_gap", grant_o, 0);
    tick();
    serve(0, 1, 0, 1);
    last_grant = 0;
    tick();

    // Slave never answers m0: abort T+1 cycles after the request.
    set_req(0, 1);
    for (int k = 0; k <= T; k++) begin
      tick();
      if (k == 3) set_req(1, 1);
      #1;
      if (k < T) begin
        check("tmo_wait_err", m0_err_o, 0);
        check("tmo_wait_stb", s_stb_o, 1);
      end
    end
    check("tmo_err", m0_err_o, 1);
    check("tmo_data", m0_dat_o, TDATA);
    check("tmo_s_cyc", s_cyc_o, 0);
    check("tmo_grant", grant_o, 2'b01);
    check("tmo_m1_resp", {m1_ack_o, m1_err_o}, 0);
    tmo_model++;
    last_grant = 0;
    drive(0, 0);
    tick();
    check("tmo_idle", grant_o, 0);
    check("tmo_count", timeout_count_o, 16'(tmo_model));
    tick();
    serve(1, 1, 0, 1);
    last_grant = 1;
    tick();

    // Ack on the exact expiry cycle: response wins, no abort.
    set_req(0, 1);
    tick();
    serve(0, T - 1, 0, 1);
    last_grant = 0;
    check("race_err", m0_err_o, 0);
    tick();
    check("race_idle", grant_o, 0);
    check("race_tmo", timeout_count_o, 16'(tmo_model));

    // Reset in the middle of an m1 access.
    set_req(1, 1);
    tick();
    #1;
    check("rst_pre_grant", grant_o, 2'b10);
    rst = 1'b1;
    s_ack_i = 1'b1;
    #1;
    check("rst_kill_resp", {m1_ack_o, m1_err_o}, 0);
    tick();
    rst = 1'b0;
    s_ack_i = 1'b0;
    last_grant = 1;
    tmo_model = 0;
    set_req(0, 1);
    #1;
    check("rst_mid_grant", grant_o, 0);
    check("rst_mid_s_cyc", s_cyc_o, 0);
    check("rst_mid_resp", {m1_ack_o, m1_err_o}, 0);
    check("rst_mid_tmo", timeout_count_o, 0);
    tick();
    serve(0, 0, 0, 1);
    last_grant = 0;
    tick();
    check("rst_after_idle", grant_o, 0);
    tick();
    serve(1, 0, 0, 1);
    last_grant = 1;
    tick();

    // Randomized contests against the model.
    for (int n = 0; n < 8; n++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      contest(r0, r1);
    end
    check("final_tmo", timeout_count_o, 16'(tmo_model));

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

endmodule
